gemm_row_ctrl: RTL
==================

GEMM_ROW_CTRL -- requirements
Module: gemm_row_ctrl

Interface
REQ-001 SHALL have parameters: INP_WIDTH, default 8, input element width; WGT_WIDTH, default 8, weight element width; ACC_WIDTH, default 32, accumulator lane width; ADDR_WIDTH, default 11, buffer address width.
REQ-002 SHALL derive IT_WIDTH=INP_WIDTH*16, WT_WIDTH=WGT_WIDTH*16 and AT_WIDTH=ACC_WIDTH*16 (16 lanes).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  command strobe, sampled in IDLE only.
- uop_cnt  in  8  number of uops in the command.
- inp_base, wgt_base, acc_base  in  ADDR_WIDTH each  buffer base addresses.
- reset_acc  in  1  when 1, start each uop from zero instead of acc_rd_data.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- inp_rd_en / inp_rd_addr  out  1 / ADDR_WIDTH  input buffer read port.
- inp_rd_data  in  IT_WIDTH  input read data.
- wgt_rd_en / wgt_rd_addr  out  1 / ADDR_WIDTH  weight buffer read port.
- wgt_rd_data  in  WT_WIDTH  weight read data.
- acc_rd_en / acc_rd_addr  out  1 / ADDR_WIDTH  accumulator buffer read port.
- acc_rd_data  in  AT_WIDTH  accumulator read data.
- acc_wr_en / acc_wr_addr / acc_wr_data  out  1 / ADDR_WIDTH / AT_WIDTH  accumulator buffer write port.
- i_row / w_row / a_row  out  IT_WIDTH / WT_WIDTH / AT_WIDTH  operands to the combinational 16-lane MAC row.
- o_row  in  AT_WIDTH  MAC row result; lane j = a_row[j] + i_row[j]*w_row[j], valid in the same cycle.
REQ-004 SHALL treat all buffer read ports as having 1-cycle latency: data is valid in the cycle after the enable.

Function
REQ-005 SHALL implement FSM states IDLE, FETCH, MAC, WB, DONE; the counters are k (uop index, 8 bits) and r (row index, 4 bits).
REQ-006 IDLE: on start=1 with uop_cnt!=0, SHALL latch uop_cnt, all bases and reset_acc, clear k, and go to FETCH.
REQ-007 IDLE: on start=1 with uop_cnt=0, SHALL go to DONE directly with no buffer access.
REQ-008 FETCH (1 cycle) SHALL assert:
- inp_rd_en, with inp_rd_addr=inp_base+k;
- wgt_rd_en, with wgt_rd_addr=wgt_base;
- acc_rd_en, with acc_rd_addr=acc_base+k, only if reset_acc=0.
Then SHALL go to MAC with r=0.
REQ-009 MAC (16 cycles, r=0..15) SHALL drive:
- w_row=wgt_rd_data;
- i_row: every lane = element r of V, where V=inp_rd_data when r=0, else inp_q;
- a_row: when r=0, acc_rd_data (or 0 if reset_acc); else acc_q.
REQ-010 In MAC, SHALL register acc_q<=o_row every cycle, and register inp_q<=inp_rd_data at r=0.
REQ-011 In MAC for r=0..14, SHALL assert wgt_rd_en with wgt_rd_addr=wgt_base+r+1; wgt_rd_en SHALL be 0 at r=15. After r=15, SHALL go to WB.
REQ-012 WB (1 cycle) SHALL assert acc_wr_en with acc_wr_addr=acc_base+k and acc_wr_data=acc_q. Then SHALL go to FETCH with k+1 if k+1<uop_cnt, else to DONE.
REQ-013 DONE (1 cycle) SHALL assert done=1 and return to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 Each uop SHALL take 18 cycles. With start sampled at cycle t, done SHALL be high at cycle t+1+18*uop_cnt.
REQ-016 All address sums SHALL wrap modulo 2^ADDR_WIDTH.
REQ-017 The block SHALL perform no arithmetic on data. Lane sums and sign handling belong to the MAC row; acc_q is stored unmodified.
REQ-018 start SHALL be ignored outside IDLE; a start coincident with DONE SHALL be ignored.
REQ-019 All enables and done SHALL be 0 outside the states named above. i_row, w_row and a_row SHALL be 0 outside MAC.

Reset
REQ-020 On rst_n=0 at a clock edge, SHALL return to IDLE and clear k, r, acc_q, inp_q and all latched configuration.
REQ-021 During reset, busy, done, all *_en outputs and all address/data outputs SHALL be 0.
REQ-022 A reset in any state, including mid-MAC or in WB, SHALL abort the command; no acc write and no done pulse SHALL occur for it.
REQ-023 The first start SHALL be accepted in the cycle after rst_n is released.

Verification
REQ-024 uop_cnt=1, reset_acc=1, every inp element=1, every wgt element=2 -> one write at acc_base, every lane 32; done at t+19.
REQ-025 uop_cnt=3, reset_acc=0, acc preloaded with 100 per lane, inp=1, wgt=1 -> lanes 116 written at acc_base+0..2; done at t+55; busy high t+1..t+55.
REQ-026 uop_cnt=0 -> done at t+1; no *_en asserted.
REQ-027 inp_base=2047, uop_cnt=2 -> inp_rd_addr 2047 then 0; wgt_rd_addr sequence wgt_base..wgt_base+15 per uop.
REQ-028 rst_n low at MAC r=7 -> no acc_wr_en, no done; all outputs 0 next cycle; a new start then completes normally.
REQ-029 start pulsed while busy, and again coincident with DONE -> ignored; exactly one done per accepted command.

Source files
------------

// File: rtl/gemm_row_ctrl.sv
// rtl/gemm_row_ctrl.sv - sequencer feeding a 16-lane MAC row from input, weight and accumulator buffers
module gemm_row_ctrl #(
    parameter int INP_WIDTH  = 8,
    parameter int WGT_WIDTH  = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 11,
    localparam int IT_WIDTH  = INP_WIDTH * 16,
    localparam int WT_WIDTH  = WGT_WIDTH * 16,
    localparam int AT_WIDTH  = ACC_WIDTH * 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            uop_cnt,
    input  logic [ADDR_WIDTH-1:0] inp_base,
    input  logic [ADDR_WIDTH-1:0] wgt_base,
    input  logic [ADDR_WIDTH-1:0] acc_base,
    input  logic                  reset_acc,
    output logic                  busy,
    output logic                  done,
    output logic                  inp_rd_en,
    output logic [ADDR_WIDTH-1:0] inp_rd_addr,
    input  logic [IT_WIDTH-1:0]   inp_rd_data,
    output logic                  wgt_rd_en,
    output logic [ADDR_WIDTH-1:0] wgt_rd_addr,
    input  logic [WT_WIDTH-1:0]   wgt_rd_data,
    output logic                  acc_rd_en,
    output logic [ADDR_WIDTH-1:0] acc_rd_addr,
    input  logic [AT_WIDTH-1:0]   acc_rd_data,
    output logic                  acc_wr_en,
    output logic [ADDR_WIDTH-1:0] acc_wr_addr,
    output logic [AT_WIDTH-1:0]   acc_wr_data,
    output logic [IT_WIDTH-1:0]   i_row,
    output logic [WT_WIDTH-1:0]   w_row,
    output logic [AT_WIDTH-1:0]   a_row,
    input  logic [AT_WIDTH-1:0]   o_row
);

    typedef enum logic [2:0] {IDLE, FETCH, MAC, WB, DONE} state_t;

    state_t                state_q;
    logic [7:0]            cnt_q;
    logic [7:0]            k_q;
    logic [3:0]            r_q;
    logic [ADDR_WIDTH-1:0] inp_base_q;
    logic [ADDR_WIDTH-1:0] wgt_base_q;
    logic [ADDR_WIDTH-1:0] acc_base_q;
    logic                  reset_acc_q;
    logic [AT_WIDTH-1:0]   acc_q;
    logic [IT_WIDTH-1:0]   inp_q;

    logic [8:0]            k_inc_d;
    logic [ADDR_WIDTH-1:0] k_off;
    logic [ADDR_WIDTH-1:0] r_off;
    logic [IT_WIDTH-1:0]   inp_src;

    assign k_inc_d = {1'b0, k_q} + 9'd1;
    assign k_off   = ADDR_WIDTH'(k_q);
    assign r_off   = ADDR_WIDTH'(r_q) + ADDR_WIDTH'(1);
    // Row 0 takes the input vector straight off the read port; later rows reuse the captured copy.
    assign inp_src = (r_q == 4'd0) ? inp_rd_data : inp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            r_q         <= '0;
            inp_base_q  <= '0;
            wgt_base_q  <= '0;
            acc_base_q  <= '0;
            reset_acc_q <= 1'b0;
            acc_q       <= '0;
            inp_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (uop_cnt != 8'd0) begin
                            cnt_q       <= uop_cnt;
                            inp_base_q  <= inp_base;
                            wgt_base_q  <= wgt_base;
                            acc_base_q  <= acc_base;
                            reset_acc_q <= reset_acc;
                            k_q         <= '0;
                            state_q     <= FETCH;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                FETCH: begin
                    r_q     <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= o_row;
                    if (r_q == 4'd0) begin
                        inp_q <= inp_rd_data;
                    end
                    r_q <= r_q + 4'd1;
                    if (r_q == 4'd15) begin
                        state_q <= WB;
                    end
                end
                WB: begin
                    if (k_inc_d < {1'b0, cnt_q}) begin
                        k_q     <= k_inc_d[7:0];
                        state_q <= FETCH;
                    end else begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode the registered state; holding rst_n low forces them quiet immediately.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        inp_rd_en   = 1'b0;
        inp_rd_addr = '0;
        wgt_rd_en   = 1'b0;
        wgt_rd_addr = '0;
        acc_rd_en   = 1'b0;
        acc_rd_addr = '0;
        acc_wr_en   = 1'b0;
        acc_wr_addr = '0;
        acc_wr_data = '0;
        i_row       = '0;
        w_row       = '0;
        a_row       = '0;
        if (rst_n) begin
            busy = (state_q != IDLE);
            case (state_q)
                FETCH: begin
                    inp_rd_en   = 1'b1;
                    inp_rd_addr = inp_base_q + k_off;
                    wgt_rd_en   = 1'b1;
                    wgt_rd_addr = wgt_base_q;
                    if (!reset_acc_q) begin
                        acc_rd_en   = 1'b1;
                        acc_rd_addr = acc_base_q + k_off;
                    end
                end
                MAC: begin
                    w_row = wgt_rd_data;
                    i_row = {16{inp_src[int'(r_q)*INP_WIDTH +: INP_WIDTH]}};
                    if (r_q != 4'd0) begin
                        a_row = acc_q;
                    end else if (!reset_acc_q) begin
                        a_row = acc_rd_data;
                    end
                    if (r_q != 4'd15) begin
                        wgt_rd_en   = 1'b1;
                        wgt_rd_addr = wgt_base_q + r_off;
                    end
                end
                WB: begin
                    acc_wr_en   = 1'b1;
                    acc_wr_addr = acc_base_q + k_off;
                    acc_wr_data = acc_q;
                end
                DONE: begin
                    done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
